// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton
// Registered, flow-controlled 1-to-NUM_OUT word demultiplexer. A single holding register
// sits between the input handshake and the output lanes. This gives one cycle of latency
// and, because a drain and a load can happen on the same edge, full throughput.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    input word
//   in_valid   input word present
//   in_ready   block accepts in_data this cycle
//   in_sel     destination lane in select mode (ignored in round-robin mode)
//   out_data   lane i at [i*WORD_SIZE +: WORD_SIZE]; unselected lanes read zero
//   out_valid  one-hot or zero; lane holds a word
//   out_ready  per-lane downstream accept
//   cur_chan   round-robin pointer (always 0 in select mode)
//   sel_err    sticky: a word arrived with in_sel >= NUM_OUT
module demux_stream_1ton #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned NUM_OUT   = 4,
   parameter int unsigned SEL_W     = $clog2(NUM_OUT),
   parameter int unsigned RR_MODE   = 0,
   parameter int unsigned BURST_LEN = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WORD_SIZE-1:0]          in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SEL_W-1:0]              in_sel,
   output logic [NUM_OUT*WORD_SIZE-1:0]  out_data,
   output logic [NUM_OUT-1:0]            out_valid,
   input  logic [NUM_OUT-1:0]            out_ready,
   output logic [SEL_W-1:0]              cur_chan,
   output logic                          sel_err
);

   localparam logic [SEL_W:0]   NumOutExt = (SEL_W + 1)'(NUM_OUT);
   localparam logic [SEL_W-1:0] LastLane  = SEL_W'(NUM_OUT - 1);
   localparam logic [7:0]       BurstLast = 8'(BURST_LEN - 1);

   logic [WORD_SIZE-1:0] hold_data_q, hold_data_d;
   logic [SEL_W-1:0]     hold_dest_q, hold_dest_d;
   logic                 hold_full_q, hold_full_d;
   logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [7:0]           burst_cnt_q, burst_cnt_d;
   logic                 sel_err_q, sel_err_d;

   logic                 lane_ready;
   logic                 drain;
   logic                 accept;
   logic                 sel_bad;
   logic [SEL_W-1:0]     dest;

   // Ready of the lane currently addressed by the holding register. The loop avoids
   // indexing out_ready with an out-of-range value when NUM_OUT is not a power of 2.
   always_comb begin
      lane_ready = 1'b0;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
         if (hold_dest_q == SEL_W'(i)) begin
            lane_ready = out_ready[i];
         end
      end
   end

   // in_ready depends only on register state and out_ready, never on in_valid.
   always_comb begin
      drain    = hold_full_q && lane_ready;
      in_ready = !hold_full_q || lane_ready;
      accept   = in_valid && in_ready;
      dest     = (RR_MODE != 0) ? rr_ptr_q : in_sel;
      sel_bad  = (RR_MODE == 0) && ({1'b0, in_sel} >= NumOutExt);
   end

   always_comb begin
      hold_data_d = hold_data_q;
      hold_dest_d = hold_dest_q;
      hold_full_d = hold_full_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      sel_err_d   = sel_err_q;

      if (drain) begin
         hold_full_d = 1'b0;
      end

      if (accept) begin
         // A word with an invalid select completes its handshake but is discarded.
         if (sel_bad) begin
            sel_err_d = 1'b1;
         end else begin
            hold_data_d = in_data;
            hold_dest_d = dest;
            hold_full_d = 1'b1;
         end

         if (RR_MODE != 0) begin
            if (burst_cnt_q == BurstLast) begin
               burst_cnt_d = '0;
               rr_ptr_d    = (rr_ptr_q == LastLane) ? '0 : rr_ptr_q + 1'b1;
            end else begin
               burst_cnt_d = burst_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_data_q <= '0;
         hold_dest_q <= '0;
         hold_full_q <= 1'b0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_dest_q <= hold_dest_d;
         hold_full_q <= hold_full_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         sel_err_q   <= sel_err_d;
      end
   end

   // Outputs decode straight from the holding register, so they are stable under
   // backpressure and unselected lanes read zero.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
         if (hold_full_q && (hold_dest_q == SEL_W'(i))) begin
            out_valid[i]                       = 1'b1;
            out_data[i*WORD_SIZE +: WORD_SIZE] = hold_data_q;
         end
      end
      cur_chan = rr_ptr_q;
      sel_err  = sel_err_q;
   end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton. Three instances are exercised in parallel:
//   dut 0: NUM_OUT=3, select mode (non-power-of-2, invalid selects possible)
//   dut 1: NUM_OUT=4, round-robin, BURST_LEN=2
//   dut 2: NUM_OUT=5, round-robin, BURST_LEN=3
// The stimulus side pushes each accepted word, with its expected lane, into a
// per-instance queue. The monitor compares the lanes against the queue head on every
// falling edge and pops the word once it leaves.
module tb_demux_stream_1ton;

   localparam int ND = 3;
   localparam int ML = 5;
   localparam int MW = ML * 16;

   typedef struct {
      int          lane;
      logic [15:0] data;
   } exp_t;

   logic          clk;
   logic          reset;
   logic [15:0]   in_data   [ND];
   logic          in_valid  [ND];
   logic [2:0]    in_sel    [ND];
   logic [ML-1:0] out_ready [ND];
   logic          in_ready  [ND];
   logic [ML-1:0] out_valid [ND];
   logic [MW-1:0] out_data  [ND];
   logic [2:0]    cur_chan  [ND];
   logic          sel_err   [ND];

   logic [2:0]  ov0;
   logic [3:0]  ov1;
   logic [4:0]  ov2;
   logic [47:0] od0;
   logic [63:0] od1;
   logic [79:0] od2;
   logic [1:0]  cc0;
   logic [1:0]  cc1;
   logic [2:0]  cc2;

   exp_t sb_q [ND][$];
   int   acc_n   [ND];
   bit   err_m   [ND];
   bit   exp_rdy [ND];
   bit   started;
   int   n_checks;
   int   n_errs;

   function automatic int nout(input int d);
      return (d == 0) ? 3 : (d == 1) ? 4 : 5;
   endfunction

   function automatic bit rrm(input int d);
      return d != 0;
   endfunction

   function automatic int blen(input int d);
      return (d == 2) ? 3 : (d == 1) ? 2 : 1;
   endfunction

   function automatic int selmax(input int d);
      return (d == 2) ? 7 : 3;
   endfunction

   demux_stream_1ton #(
      .WORD_SIZE(16), .NUM_OUT(3), .SEL_W(2), .RR_MODE(0), .BURST_LEN(1)
   ) u_dut0 (
      .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .in_sel(in_sel[0][1:0]), .out_data(od0), .out_valid(ov0),
      .out_ready(out_ready[0][2:0]), .cur_chan(cc0), .sel_err(sel_err[0])
   );

   demux_stream_1ton #(
      .WORD_SIZE(16), .NUM_OUT(4), .SEL_W(2), .RR_MODE(1), .BURST_LEN(2)
   ) u_dut1 (
      .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .in_sel(in_sel[1][1:0]), .out_data(od1), .out_valid(ov1),
      .out_ready(out_ready[1][3:0]), .cur_chan(cc1), .sel_err(sel_err[1])
   );

   demux_stream_1ton #(
      .WORD_SIZE(16), .NUM_OUT(5), .SEL_W(3), .RR_MODE(1), .BURST_LEN(3)
   ) u_dut2 (
      .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .in_sel(in_sel[2]), .out_data(od2), .out_valid(ov2),
      .out_ready(out_ready[2]), .cur_chan(cc2), .sel_err(sel_err[2])
   );

   assign out_valid[0] = {2'b0, ov0};
   assign out_valid[1] = {1'b0, ov1};
   assign out_valid[2] = ov2;
   assign out_data[0]  = {32'b0, od0};
   assign out_data[1]  = {16'b0, od1};
   assign out_data[2]  = od2;
   assign cur_chan[0]  = {1'b0, cc0};
   assign cur_chan[1]  = {1'b0, cc1};
   assign cur_chan[2]  = cc2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input logic [MW-1:0] act,
                      input logic [MW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
      end
   endtask

   // Monitor: outputs seen before each rising edge must match the queue head.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         logic [ML-1:0] ev;
         logic [MW-1:0] ed;
         bit            full;
         bit            leaves;
         int            ln;
         ev     = '0;
         ed     = '0;
         full   = sb_q[d].size() > 0;
         leaves = 1'b0;
         ln     = 0;
         if (full) begin
            ln                 = sb_q[d][0].lane;
            ev[ln]             = 1'b1;
            ed[ln*16 +: 16]    = sb_q[d][0].data;
            leaves             = out_ready[d][ln];
         end
         exp_rdy[d] = !full || leaves;
         if (started) begin
            chk("out_valid", d, MW'(out_valid[d]), MW'(ev));
            chk("out_data", d, out_data[d], ed);
            chk("in_ready", d, MW'(in_ready[d]), MW'(exp_rdy[d]));
            chk("cur_chan", d, MW'(cur_chan[d]),
                MW'(rrm(d) ? (acc_n[d] / blen(d)) % nout(d) : 0));
            chk("sel_err", d, MW'(sel_err[d]), MW'(err_m[d]));
         end
         if (reset) begin
            sb_q[d].delete();
            acc_n[d] = 0;
            err_m[d] = 1'b0;
         end else if (leaves) begin
            void'(sb_q[d].pop_front());
         end
      end
   end

   // Advance one clock; record every word the model says is accepted on this edge.
   task automatic step();
      @(posedge clk);
      if (!reset) begin
         for (int d = 0; d < ND; d++) begin
            if (in_valid[d] && exp_rdy[d]) begin
               exp_t e;
               e.data = in_data[d];
               e.lane = rrm(d) ? (acc_n[d] / blen(d)) % nout(d) : int'(in_sel[d]);
               if (!rrm(d) && int'(in_sel[d]) >= nout(d)) begin
                  err_m[d] = 1'b1;
               end else begin
                  sb_q[d].push_back(e);
               end
               acc_n[d]++;
            end
         end
      end
      #1;
   endtask

   task automatic drive_all(input bit v, input logic [15:0] dat, input logic [2:0] sel,
                            input logic [ML-1:0] rdy);
      for (int d = 0; d < ND; d++) begin
         in_valid[d]  = v;
         in_data[d]   = dat;
         in_sel[d]    = sel;
         out_ready[d] = rdy;
      end
   endtask

   task automatic drive_rand();
      for (int d = 0; d < ND; d++) begin
         in_valid[d]  = $urandom_range(0, 9) < 7;
         in_data[d]   = 16'($urandom);
         in_sel[d]    = 3'($urandom_range(0, selmax(d)));
         out_ready[d] = ML'($urandom) | ML'($urandom);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      started  = 1'b0;
      for (int d = 0; d < ND; d++) begin
         acc_n[d]   = 0;
         err_m[d]   = 1'b0;
         exp_rdy[d] = 1'b0;
      end
      reset = 1'b1;
      drive_all(1'b0, 16'h0, 3'd0, '1);
      step();
      step();
      reset   = 1'b0;
      started = 1'b1;
      step();

      // Single word to lane 2, then idle.
      drive_all(1'b1, 16'h1111, 3'd2, '1);
      step();
      drive_all(1'b0, 16'h0, 3'd0, '1);
      step();
      step();

      // Back-to-back words to different lanes (sel 3 is invalid on the 3-lane instance).
      drive_all(1'b1, 16'hA000, 3'd0, '1);
      step();
      drive_all(1'b1, 16'hB001, 3'd3, '1);
      step();
      drive_all(1'b0, 16'h0, 3'd0, '1);
      step();
      step();

      // Backpressure on lane 1 for three cycles with a second word pending.
      drive_all(1'b1, 16'h00FF, 3'd1, 5'b11101);
      step();
      drive_all(1'b1, 16'h0100, 3'd1, 5'b11101);
      repeat (3) step();
      drive_all(1'b1, 16'h0100, 3'd1, '1);
      step();
      drive_all(1'b0, 16'h0, 3'd0, '1);
      step();
      step();

      // Clear state, then a ten-word stream with toggling select.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         drive_all(1'b1, 16'(i), 3'(i % 2), '1);
         step();
      end
      drive_all(1'b0, 16'h0, 3'd0, '1);
      step();
      step();

      // Random traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         drive_rand();
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      // Reset while words are held under backpressure.
      drive_all(1'b1, 16'h5A5A, 3'd1, '0);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive_all(1'b0, 16'h0, 3'd0, '0);
      repeat (3) step();

      // Drain everything and confirm nothing was lost.
      drive_all(1'b0, 16'h0, 3'd0, '1);
      repeat (6) step();
      @(negedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         chk("drained", d, MW'(sb_q[d].size()), MW'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/demux_stream_1ton.md
# demux_stream_1toN

Registered, flow-controlled 1-to-NUM_OUT word demultiplexer with valid/ready handshakes on the input and on every output lane. It routes activation/weight words from the shared feature buffer into the parallel MAC lanes of the digit-recognition datapath. It has two steering modes: explicit select, and automatic round-robin that advances after a programmable burst length. A one-word holding register gives one cycle of latency and full throughput.

## Interface
- WORD_SIZE, 16, width of one data word
- NUM_OUT, 4, number of output lanes (2..16)
- SEL_W, $clog2(NUM_OUT), width of the select and pointer fields
- RR_MODE, 0, 0 = steer by in_sel; 1 = round-robin, in_sel ignored
- BURST_LEN, 1, words sent to one lane before the round-robin pointer advances (1..255)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- in_data  in  WORD_SIZE  input word
- in_valid  in  1  input word present
- in_ready  out  1  block accepts in_data this cycle
- in_sel  in  SEL_W  destination lane (RR_MODE=0 only), sampled with the word
- out_data  out  NUM_OUT*WORD_SIZE  lane i occupies bits [i*WORD_SIZE +: WORD_SIZE]
- out_valid  out  NUM_OUT  one-hot or zero; lane holds a word
- out_ready  in  NUM_OUT  per-lane downstream accept
- cur_chan  out  SEL_W  current round-robin pointer (reads 0 when RR_MODE=0)
- sel_err  out  1  sticky flag: a word arrived with in_sel >= NUM_OUT

## Operation
- Holding register state: hold_data, hold_dest, hold_full.
- Destination of an incoming word:
  - RR_MODE=0: in_sel.
  - RR_MODE=1: rr_ptr.
- Input accept: in_ready = !hold_full || out_ready[hold_dest]. A word transfers when in_valid && in_ready.
- Output drive:
  - out_valid[hold_dest] = hold_full; every other out_valid bit is 0.
  - out_data lane hold_dest = hold_data. All non-selected lanes and all lanes while empty drive 0, so unselected lanes read zero.
  - A word leaves when out_valid[i] && out_ready[i]. out_ready on lanes that are not valid is ignored.
- Register update each cycle:
  - Drain only: hold_full clears.
  - Accept (with or without a simultaneous drain): hold_data and hold_dest load, hold_full stays or goes 1.
- Invalid select (RR_MODE=0, in_sel >= NUM_OUT, non-power-of-2 NUM_OUT):
  - The word is accepted (handshake completes) and discarded. The holding register is unchanged.
  - sel_err sets and stays set until reset.
- Round-robin:
  - burst_cnt (8 bit) increments on each accepted word.
  - When burst_cnt reaches BURST_LEN-1 on an accept, burst_cnt returns to 0 and rr_ptr advances.
  - rr_ptr wraps from NUM_OUT-1 to 0.
  - The pointer never advances without an accepted word, so a stalled lane stalls the stream. There is no skipping.

## Timing
- Reset values: out_valid=0, out_data=0, cur_chan=0, sel_err=0, hold_full=0, rr_ptr=0, burst_cnt=0. in_ready is 1 in the first cycle after reset.
- Latency: a word accepted at edge N is valid on its lane from edge N to N+1 onward, i.e. 1 cycle.
- Throughput: 1 word/cycle while the destination lane keeps out_ready high, including back-to-back words to different lanes (drain and load on the same edge).
- in_ready is combinational from out_ready and hold_dest. There is no path from in_valid to in_ready.
- Backpressure: while hold_full && !out_ready[hold_dest], in_ready=0. out_data and out_valid must stay stable until the word drains.
- Reset mid-operation: the held word is dropped, pointers clear, and sel_err clears. Reset overrides a simultaneous accept or drain.
- cur_chan updates on the same edge as the accept that completes a burst.

## Test plan
- Select mode, NUM_OUT=4: send 0x1111 sel=2 with all out_ready=1 -> next cycle out_valid=4'b0100, lane2=0x1111, lanes 0/1/3=0; the following cycle out_valid=0.
- Back-to-back: 0xA000 sel=0 then 0xB001 sel=3 on consecutive cycles, out_ready all 1 -> in_ready held 1; lane0 valid one cycle, then lane3 valid one cycle; no bubbles.
- Backpressure: word 0x00FF sel=1, out_ready[1]=0 for 3 cycles -> in_ready=0 and lane1=0x00FF stable for 3 cycles; release -> drains, and a pending 0x0100 sel=1 loads on the same edge.
- Invalid select, NUM_OUT=3: in_sel=3, data 0xDEAD -> handshake completes, no out_valid, sel_err=1 and stays 1 through later valid traffic until reset.
- Round-robin, NUM_OUT=4, BURST_LEN=2: 10 words 1..10 -> lanes 0,0,1,1,2,2,3,3,0,0; cur_chan goes 0,1,2,3,0; in_sel toggling has no effect.
- Reset mid-stream: assert reset while holding a word with rr_ptr=2 -> next cycle out_valid=0, out_data=0, cur_chan=0, sel_err=0, in_ready=1.
